// File: rtl/imm_operand_encoder_if.sv
// Request/result bundle for imm_operand_encoder.
// The is_mem_cmd field is present only when IMM_ENC_MEM_OFFSET_EN is defined.
interface imm_operand_encoder_if #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12
);
  logic                             start;
  logic [WORD_WIDTH-1:0]            value;
`ifdef IMM_ENC_MEM_OFFSET_EN
  logic                             is_mem_cmd;
`endif
  logic                             busy;
  logic                             done;
  logic                             found;
  logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand;

`ifdef IMM_ENC_MEM_OFFSET_EN
  modport master (output start, value, is_mem_cmd,
                  input  busy, done, found, shift_operand);
  modport slave  (input  start, value, is_mem_cmd,
                  output busy, done, found, shift_operand);
`else
  modport master (output start, value,
                  input  busy, done, found, shift_operand);
  modport slave  (input  start, value,
                  output busy, done, found, shift_operand);
`endif
endinterface

// File: rtl/imm_operand_encoder.sv
// Searches rotations of a 32-bit constant, one per cycle, for an {rotate_imm, imm8} encoding.
// Optional macro IMM_ENC_MEM_OFFSET_EN adds a single-cycle signed 12-bit offset path.
module imm_operand_encoder #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  imm_operand_encoder_if.slave  bus
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t                           r_state;
  logic [3:0]                       r_rot;
  logic [WORD_WIDTH-1:0]            r_value;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_found;
  logic [SHIFTER_OPERAND_WIDTH-1:0] r_shift_operand;

  logic [5:0]                       w_shamt;
  logic [WORD_WIDTH-1:0]            w_rol;
  logic                             w_hit;

  // ROL by 2*rot; the right shift by 32 at rot=0 yields zero, leaving the plain value.
  assign w_shamt = {1'b0, r_rot, 1'b0};
  assign w_rol   = (r_value << w_shamt) | (r_value >> (6'd32 - w_shamt));
  assign w_hit   = (w_rol[WORD_WIDTH-1:8] == '0);

`ifdef IMM_ENC_MEM_OFFSET_EN
  logic w_mem_fits;
  assign w_mem_fits = (&bus.value[WORD_WIDTH-1:11]) | ~(|bus.value[WORD_WIDTH-1:11]);
`endif

  // NOTE: all state in this block uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_rot           <= '0;
      r_value         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_found         <= 1'b0;
      r_shift_operand <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_value         <= bus.value;
            r_rot           <= '0;
            r_found         <= 1'b0;
            r_shift_operand <= '0;
`ifdef IMM_ENC_MEM_OFFSET_EN
            if (bus.is_mem_cmd) begin
              r_done          <= 1'b1;
              r_found         <= w_mem_fits;
              r_shift_operand <= w_mem_fits ? bus.value[11:0] : '0;
            end else begin
              r_state <= SEARCH;
              r_busy  <= 1'b1;
            end
`else
            r_state <= SEARCH;
            r_busy  <= 1'b1;
`endif
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_shift_operand <= {r_rot, w_rol[7:0]};
            r_found         <= 1'b1;
            r_done          <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= IDLE;
          end else if (r_rot == 4'd15) begin
            r_shift_operand <= '0;
            r_found         <= 1'b0;
            r_done          <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= IDLE;
          end else begin
            r_rot <= r_rot + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.found         = r_found;
  assign bus.shift_operand = r_shift_operand;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Directed, table-driven bench for imm_operand_encoder, plus hand-written
// sequences for ignored start, back-to-back start and mid-search reset.
module tb_imm_operand_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  imm_operand_encoder_if bus ();

  imm_operand_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        mem;
    logic        exp_found;
    logic [11:0] exp_op;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request; latency counted in edges after the start-sampling edge.
  task automatic run_req(input logic [31:0] v, input logic ef, input logic [11:0] eop,
                         input int elat, input string tag);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (elat > 0) begin
      check({tag, " busy after start"}, 32'(bus.busy), 32'd1);
      check({tag, " found cleared"}, 32'(bus.found), 32'd0);
      check({tag, " operand cleared"}, 32'(bus.shift_operand), 32'd0);
    end
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " found"}, 32'(bus.found), 32'(ef));
    check({tag, " operand"}, 32'(bus.shift_operand), 32'(eop));
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, 32'(bus.done), 32'd0);
    check({tag, " found hold"}, 32'(bus.found), 32'(ef));
    check({tag, " operand hold"}, 32'(bus.shift_operand), 32'(eop));
  endtask

  initial begin
    int n;
    int dones;

    bus.start = 1'b0;
    bus.value = '0;
`ifdef IMM_ENC_MEM_OFFSET_EN
    bus.is_mem_cmd = 1'b0;
`endif

    vecs.push_back('{32'h000000FF, 1'b0, 1'b1, 12'h0FF, 1});
    vecs.push_back('{32'hFF000000, 1'b0, 1'b1, 12'h4FF, 5});
    vecs.push_back('{32'hF000000F, 1'b0, 1'b1, 12'h2FF, 3});
    vecs.push_back('{32'h00000104, 1'b0, 1'b1, 12'hF41, 16});
    vecs.push_back('{32'h00000101, 1'b0, 1'b0, 12'h000, 16});
    vecs.push_back('{32'h00000000, 1'b0, 1'b1, 12'h000, 1});
    vecs.push_back('{32'h000003FC, 1'b0, 1'b1, 12'hFFF, 16});
    vecs.push_back('{32'h00AB0000, 1'b0, 1'b1, 12'h8AB, 9});
    vecs.push_back('{32'h80000001, 1'b0, 1'b1, 12'h106, 2});
`ifdef IMM_ENC_MEM_OFFSET_EN
    vecs.push_back('{32'hFFFFF800, 1'b1, 1'b1, 12'h800, 0});
    vecs.push_back('{32'h00000800, 1'b1, 1'b0, 12'h000, 0});
    vecs.push_back('{32'h000007FF, 1'b1, 1'b1, 12'h7FF, 0});
    vecs.push_back('{32'h00000800, 1'b0, 1'b1, 12'hB02, 12});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset found", 32'(bus.found), 32'd0);
    check("reset operand", 32'(bus.shift_operand), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
`ifdef IMM_ENC_MEM_OFFSET_EN
      bus.is_mem_cmd = vecs[i].mem;
`endif
      run_req(vecs[i].value, vecs[i].exp_found, vecs[i].exp_op, vecs[i].exp_lat,
              $sformatf("vec%0d", i));
    end
`ifdef IMM_ENC_MEM_OFFSET_EN
    bus.is_mem_cmd = 1'b0;
`endif

    // Start while busy is ignored; then a new start on the done cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h00000104;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.value = 32'h000000FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.value = '0;
    n = 6;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ignored start latency", 32'(n), 32'd16);
    check("ignored start operand", 32'(bus.shift_operand), 32'h00000F41);
    check("ignored start found", 32'(bus.found), 32'd1);
    bus.start = 1'b1;
    bus.value = 32'h00000000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b accepted busy", 32'(bus.busy), 32'd1);
    check("b2b done low", 32'(bus.done), 32'd0);
    check("b2b found cleared", 32'(bus.found), 32'd0);
    @(posedge clk);
    #1;
    check("b2b done", 32'(bus.done), 32'd1);
    check("b2b found", 32'(bus.found), 32'd1);
    check("b2b operand", 32'(bus.shift_operand), 32'd0);

    // Reset at rot=7 of an unencodable search aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h00000101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre-abort busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort found", 32'(bus.found), 32'd0);
    check("abort operand", 32'(bus.shift_operand), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("no done after abort", 32'(dones), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
